// File: rtl/merge_fifo_ctrl_pkg.sv
// Shared constants and helpers for the two-channel merge FIFO.
// Covers the stored-word layout {chan, data}, the pointer width and the output-stage depth.
package merge_fifo_ctrl_pkg;

   localparam int OUT_DEPTH = 2;

   typedef enum logic {CH0 = 1'b0, CH1 = 1'b1} chan_e;

   // One extra pointer bit tells a full RAM apart from an empty one.
   function automatic int ptr_w(input int awidth);
      return awidth + 1;
   endfunction

   function automatic int chan_bit(input int dwidth);
      return dwidth;
   endfunction

endpackage

// File: rtl/merge_fifo_ctrl_tdpram.sv
// Dual-port RAM with a registered read on port 2.
// Both ports write through the port-1 clock, because this instance is always driven from one clock source.
module tdpram_v #(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 17,
   parameter int DEPTH  = 0
) (
   input  logic              clk1_i,
   input  logic              clk2_i,
   input  logic              wen1_i,
   input  logic [AWIDTH-1:0] addr1_i,
   input  logic [DWIDTH-1:0] data1_i,
   input  logic              wen2_i,
   input  logic [AWIDTH-1:0] addr2_i,
   input  logic [DWIDTH-1:0] data2_i,
   output logic [DWIDTH-1:0] q2_o
);

   localparam int NWORDS = (DEPTH == 0) ? (2 ** AWIDTH) : DEPTH;

   logic [DWIDTH-1:0] mem [NWORDS];

   always_ff @(posedge clk1_i) begin
      if (wen1_i)
         mem[addr1_i] <= data1_i;
      else if (wen2_i)
         mem[addr2_i] <= data2_i;
   end

   always_ff @(posedge clk2_i)
      q2_o <= mem[addr2_i];

endmodule

// File: rtl/merge_fifo_ctrl.sv
// Merges two sample streams into one ordered stream. Writes are picked round-robin into circular RAM storage,
// and reads drain through a registered output stage with a 2-entry skid.
module merge_fifo_ctrl
   import merge_fifo_ctrl_pkg::*;
#(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DWIDTH-1:0] s0_data_i,
   input  logic              s0_valid_i,
   output logic              s0_ready_o,
   input  logic [DWIDTH-1:0] s1_data_i,
   input  logic              s1_valid_i,
   output logic              s1_ready_o,
   output logic [DWIDTH-1:0] m_data_o,
   output logic              m_chan_o,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [AWIDTH+1:0] level_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int PTR_W    = ptr_w(AWIDTH);
   localparam int CHAN_BIT = chan_bit(DWIDTH);
   localparam int RW       = DWIDTH + 1;
   localparam int LW       = AWIDTH + 2;

   logic [PTR_W-1:0] wr_ptr, rd_ptr, occ;
   logic             rd_pend;
   logic [1:0]       out_cnt;
   chan_e            last_grant;
   logic [RW-1:0]    out_q, skid_q, ram_q, wr_word;
   logic             gnt0, gnt1, acc0, acc1, acc, pop, issue, ram_empty;
   logic [2:0]       nxt_busy;

   assign occ       = wr_ptr - rd_ptr;
   assign full_o    = (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]) &&
                      (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]);
   assign ram_empty = (wr_ptr == rd_ptr);

   // On a tie, the channel that did not win last time takes the slot.
   assign gnt0 = s0_valid_i && (!s1_valid_i || last_grant == CH1);
   assign gnt1 = s1_valid_i && (!s0_valid_i || last_grant == CH0);

   assign s0_ready_o = gnt0 && !full_o && !rst_i;
   assign s1_ready_o = gnt1 && !full_o && !rst_i;
   assign acc0       = s0_valid_i && s0_ready_o;
   assign acc1       = s1_valid_i && s1_ready_o;
   assign acc        = acc0 || acc1;
   assign wr_word    = acc1 ? {1'b1, s1_data_i} : {1'b0, s0_data_i};

   assign m_valid_o = (out_cnt != 2'd0);
   assign m_data_o  = out_q[DWIDTH-1:0];
   assign m_chan_o  = out_q[CHAN_BIT];
   assign pop       = m_valid_o && m_ready_i;

   // Count the words already headed for the output stage, so a new read always has a slot to land in.
   assign nxt_busy = 3'(out_cnt) + 3'(rd_pend) - 3'(pop);
   assign issue    = !ram_empty && (nxt_busy < 3'(OUT_DEPTH));

   assign level_o = LW'(occ) + LW'(rd_pend) + LW'(out_cnt);
   assign empty_o = (level_o == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rd_pend    <= 1'b0;
         out_cnt    <= 2'd0;
         last_grant <= CH1;
         out_q      <= '0;
         skid_q     <= '0;
      end else begin
         if (acc) begin
            wr_ptr     <= wr_ptr + PTR_W'(1);
            last_grant <= acc1 ? CH1 : CH0;
         end
         if (issue)
            rd_ptr <= rd_ptr + PTR_W'(1);
         rd_pend <= issue;

         if (pop) begin
            if (out_cnt == 2'd2) begin
               out_q <= skid_q;
               if (rd_pend)
                  skid_q <= ram_q;
               else
                  out_cnt <= 2'd1;
            end else if (rd_pend) begin
               out_q <= ram_q;
            end else begin
               out_cnt <= 2'd0;
            end
         end else if (rd_pend) begin
            if (out_cnt == 2'd0) begin
               out_q   <= ram_q;
               out_cnt <= 2'd1;
            end else begin
               skid_q  <= ram_q;
               out_cnt <= 2'd2;
            end
         end
      end
   end

   tdpram_v #(
      .AWIDTH (AWIDTH),
      .DWIDTH (RW),
      .DEPTH  (0)
   ) u_ram (
      .clk1_i  (clk_i),
      .clk2_i  (clk_i),
      .wen1_i  (acc),
      .addr1_i (wr_ptr[AWIDTH-1:0]),
      .data1_i (wr_word),
      .wen2_i  (1'b0),
      .addr2_i (rd_ptr[AWIDTH-1:0]),
      .data2_i (RW'(0)),
      .q2_o    (ram_q)
   );

endmodule

// File: tb/tb_merge_fifo_ctrl.sv
// Scoreboarded bench for merge_fifo_ctrl (AWIDTH=3). Accepted words are queued in order,
// and a negedge monitor pops the queue and compares each word against the DUT output.
module tb_merge_fifo_ctrl;

   localparam int AW = 3;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s0_data = '0, s1_data = '0;
   logic          s0_valid = 1'b0, s1_valid = 1'b0;
   logic          s0_ready, s1_ready;
   logic [DW-1:0] m_data;
   logic          m_chan, m_valid;
   logic          m_ready = 1'b0;
   logic [AW+1:0] level;
   logic          full, empty;

   merge_fifo_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .clk_i(clk), .rst_i(rst),
      .s0_data_i(s0_data), .s0_valid_i(s0_valid), .s0_ready_o(s0_ready),
      .s1_data_i(s1_data), .s1_valid_i(s1_valid), .s1_ready_o(s1_ready),
      .m_data_o(m_data), .m_chan_o(m_chan), .m_valid_o(m_valid), .m_ready_i(m_ready),
      .level_o(level), .full_o(full), .empty_o(empty)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          checks = 0, passed = 0;
   logic [DW:0] exp_q[$];
   int          first_pop_cyc = 0, last_pop_cyc = 0, npops = 0;
   logic        hold_v = 1'b0;
   logic [DW:0] hold_w = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: check each popped word, and check that a stalled output holds steady.
   always @(negedge clk) begin
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("stall_valid", 32'(m_valid), 32'(1));
            chk("stall_hold", 32'({m_chan, m_data}), 32'(hold_w));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_out: got %0h expected none", {m_chan, m_data});
            end else begin
               chk("out_word", 32'({m_chan, m_data}), 32'(exp_q.pop_front()));
            end
            if (npops == 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            npops++;
         end
         hold_v = m_valid && !m_ready;
         hold_w = {m_chan, m_data};
      end
   end

   task automatic do_reset(input int n);
      rst = 1'b1;
      exp_q.delete();
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Entered at posedge+1; returns at posedge+1 after the accept.
   task automatic send(input bit ch, input logic [DW-1:0] d, output int acc_cyc);
      bit done = 1'b0;
      acc_cyc = -1;
      if (ch) begin s1_valid = 1'b1; s1_data = d; end
      else    begin s0_valid = 1'b1; s0_data = d; end
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if ((ch && s1_valid && s1_ready) || (!ch && s0_valid && s0_ready)) begin
            exp_q.push_back({ch, d});
            acc_cyc = cyc;
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (ch) s1_valid = 1'b0; else s0_valid = 1'b0;
      if (!done) begin checks++; $display("FAIL send_timeout: got no accept expected accept of %0h", d); end
   endtask

   task automatic drain(input string nm);
      for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk(nm, 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int a0, tmp, nacc, rr_exp, got;

      // Reset with both channels requesting.
      s0_valid = 1'b1; s1_valid = 1'b1; s0_data = 16'h1111; s1_data = 16'h2222;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_s0_ready", 32'(s0_ready), 32'(0));
         chk("rst_s1_ready", 32'(s1_ready), 32'(0));
      end
      @(posedge clk); #1;
      rst = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
      @(negedge clk);
      chk("rst_m_valid", 32'(m_valid), 32'(0));
      chk("rst_level", 32'(level), 32'(0));
      chk("rst_empty", 32'(empty), 32'(1));
      chk("rst_full", 32'(full), 32'(0));
      @(posedge clk); #1;

      // Single stream: latency and back-to-back output.
      m_ready = 1'b1; npops = 0;
      send(1'b0, 16'h0001, a0);
      send(1'b0, 16'h0002, tmp);
      send(1'b0, 16'h0003, tmp);
      send(1'b0, 16'h0004, tmp);
      drain("single_drain");
      chk("single_latency", 32'(first_pop_cyc - a0), 32'(3));
      chk("single_b2b", 32'(last_pop_cyc - first_pop_cyc), 32'(3));
      chk("single_count", 32'(npops), 32'(4));

      // Round-robin: fresh reset, so s0 must win first.
      do_reset(1);
      m_ready = 1'b1; npops = 0;
      rr_exp = 0; nacc = 0;
      begin
         int i0 = 0, i1 = 0;
         s0_valid = 1'b1; s1_valid = 1'b1;
         for (int n = 0; n < 40 && nacc < 8; n++) begin
            s0_data = 16'hA000 + 16'(i0);
            s1_data = 16'hB000 + 16'(i1);
            @(negedge clk);
            if ((s0_valid && s0_ready) || (s1_valid && s1_ready)) begin
               got = (s1_valid && s1_ready) ? 1 : 0;
               chk("rr_order", 32'(got), 32'(rr_exp));
               if (got == 1) begin exp_q.push_back({1'b1, s1_data}); i1++; end
               else          begin exp_q.push_back({1'b0, s0_data}); i0++; end
               rr_exp ^= 1; nacc++;
            end
            @(posedge clk); #1;
         end
         s0_valid = 1'b0; s1_valid = 1'b0;
      end
      chk("rr_accepts", 32'(nacc), 32'(8));
      drain("rr_drain");

      // Full and backpressure: 8 RAM words + 2 in the output stage.
      do_reset(1);
      m_ready = 1'b0; nacc = 0; npops = 0;
      s1_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         s1_data = 16'hC000 + 16'(nacc);
         @(negedge clk);
         if (s1_ready) begin exp_q.push_back({1'b1, s1_data}); nacc++; end
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("full_accepts", 32'(nacc), 32'(10));
      chk("full_level", 32'(level), 32'(10));
      chk("full_flag", 32'(full), 32'(1));
      chk("full_s1_ready", 32'(s1_ready), 32'(0));
      chk("full_empty", 32'(empty), 32'(0));
      @(posedge clk); #1;
      m_ready = 1'b1;
      for (int n = 0; n < 100 && nacc < 12; n++) begin
         s1_data = 16'hC000 + 16'(nacc);
         @(negedge clk);
         if (s1_ready) begin exp_q.push_back({1'b1, s1_data}); nacc++; end
         @(posedge clk); #1;
      end
      s1_valid = 1'b0;
      chk("full_late_accepts", 32'(nacc), 32'(12));
      drain("full_drain");
      chk("full_pops", 32'(npops), 32'(12));
      @(negedge clk);
      chk("full_end_level", 32'(level), 32'(0));
      chk("full_end_empty", 32'(empty), 32'(1));
      @(posedge clk); #1;

      // Stall stability: ready toggles every cycle, 40 words wrap the pointers.
      do_reset(1);
      m_ready = 1'b1; npops = 0;
      begin
         bit done = 1'b0;
         fork
            begin
               for (int i = 0; i < 40; i++) send(i[0], 16'hD000 + 16'(i), tmp);
               for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
               done = 1'b1;
            end
            begin
               while (!done) begin
                  @(posedge clk); #1;
                  m_ready = ~m_ready;
               end
            end
         join
      end
      m_ready = 1'b1;
      drain("stall_drain");
      chk("stall_pops", 32'(npops), 32'(40));

      // Reset mid-stream with 5 words held.
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(1'b0, 16'hE000 + 16'(i), tmp);
      for (int n = 0; n < 20 && level != 5; n++) begin @(posedge clk); #1; end
      chk("mid_level_before", 32'(level), 32'(5));
      do_reset(1);
      @(negedge clk);
      chk("mid_level_after", 32'(level), 32'(0));
      chk("mid_m_valid_after", 32'(m_valid), 32'(0));
      @(posedge clk); #1;
      m_ready = 1'b1; npops = 0;
      send(1'b0, 16'h1234, tmp);
      drain("mid_drain");
      chk("mid_pops", 32'(npops), 32'(1));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
